mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 31 +++
 rtl/mult_div_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit and the E-stage decoder.
// Holds the md_op encodings, FSM states and default operation latencies.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_start_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Operands are captured at acceptance; the result is committed on the completing edge.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      md_op,
  input  logic        we,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [31:0]       a_p0, b_p0;
  md_op_e            op_p0;
  logic              accept, commit, mt_wr;
  logic [31:0]       hi_nxt, lo_nxt;
  logic [63:0]       prod, quot_rem;

  // Low 64 bits of the product of the sign- or zero-extended operands.
  function automatic logic [63:0] mul_full(input logic is_signed, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = is_signed ? $signed({{32{a[31]}}, a}) : $signed({32'd0, a});
    sb = is_signed ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
    return $unsigned(sa * sb);
  endfunction

  // Returns {remainder, quotient}; the one signed overflow case is pinned explicitly.
  function automatic logic [63:0] div_full(input logic is_signed, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic        [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (!is_signed) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = $unsigned(sa / sb);
      r = $unsigned(sa % sb);
    end
    return {r, q};
  endfunction

  assign prod     = mul_full(op_p0 == MD_MULT, a_p0, b_p0);
  assign quot_rem = div_full(op_p0 == MD_DIV, a_p0, b_p0);

  assign busy      = (state == ST_RUN);
  assign stall_req = busy | start;
  assign mt_wr     = (state == ST_IDLE) && we && !start;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && is_md_start_op(md_op)) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
          cnt_nxt   = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      ST_RUN: begin
        if (cnt == CNT_W'(1)) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A zero divisor completes the timed sequence but leaves HI/LO untouched.
  always_comb begin
    hi_nxt = HI;
    lo_nxt = LO;
    if (commit) begin
      if (is_div_op(op_p0)) begin
        if (b_p0 != '0) {hi_nxt, lo_nxt} = quot_rem;
      end else begin
        {hi_nxt, lo_nxt} = prod;
      end
    end else if (mt_wr) begin
      if (md_op == MD_MTHI)      hi_nxt = A;
      else if (md_op == MD_MTLO) lo_nxt = A;
    end
  end

  // Stage p0: operand capture and HI/LO commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
      op_p0 <= MD_NONE;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      HI    <= hi_nxt;
      LO    <= lo_nxt;
      if (accept) begin
        a_p0  <= A;
        b_p0  <= B;
        op_p0 <= md_op;
      end
    end
  end

endmodule
